// File: rtl/csr_machine_unit.sv
// Machine-mode CSR file: address decode, read-modify-write ops, trap entry/return,
// interrupt arbitration and the 64-bit mcycle/minstret counters.
module csr_machine_unit #(
   parameter int          XLEN        = 32,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter int          HART_ID     = 0,
   parameter bit          CNT_EN      = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_op,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_val,
   input  logic            mret,
   input  logic            instret_inc,
   input  logic            irq_ext,
   input  logic            irq_tim,
   input  logic            irq_sw,
   output logic            irq_take,
   output logic [XLEN-1:0] irq_cause,
   output logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] epc_out
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [XLEN-1:0] MISA_VAL   = 32'h4000_0100;
   localparam logic [XLEN-1:0] MIE_MASK   = 32'h0000_0888;
   localparam logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFD;
   localparam logic [XLEN-1:0] EPC_MASK   = 32'hFFFF_FFFC;

   logic            r_mstatus_mie;
   logic            r_mstatus_mpie;
   logic [XLEN-1:0] r_mie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_mtval;
   logic [63:0]     r_mcycle;
   logic [63:0]     r_minstret;

   logic [XLEN-1:0] w_mstatus;
   logic [XLEN-1:0] w_mip;
   logic [XLEN-1:0] w_pend;
   logic [XLEN-1:0] w_rdata;
   logic [XLEN-1:0] w_new;
   logic [XLEN-1:0] w_base;
   logic            w_mapped;
   logic            w_ro;
   logic            w_wr;

   // MPP is hardwired to machine mode, so only MIE and MPIE are stored.
   assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
   assign w_mip     = {20'b0, irq_ext, 3'b0, irq_tim, 3'b0, irq_sw, 3'b0};
   assign w_pend    = w_mip & r_mie;

   always_comb begin
      w_rdata  = '0;
      w_mapped = 1'b1;
      w_ro     = 1'b0;
      case (csr_addr)
         A_MSTATUS:   w_rdata = w_mstatus;
         A_MISA:      begin w_rdata = MISA_VAL; w_ro = 1'b1; end
         A_MIE:       w_rdata = r_mie;
         A_MTVEC:     w_rdata = r_mtvec;
         A_MSCRATCH:  w_rdata = r_mscratch;
         A_MEPC:      w_rdata = r_mepc;
         A_MCAUSE:    w_rdata = r_mcause;
         A_MTVAL:     w_rdata = r_mtval;
         A_MIP:       begin w_rdata = w_mip; w_ro = 1'b1; end
         A_MCYCLE:    begin w_rdata = CNT_EN ? r_mcycle[31:0]   : '0; w_ro = !CNT_EN; end
         A_MCYCLEH:   begin w_rdata = CNT_EN ? r_mcycle[63:32]  : '0; w_ro = !CNT_EN; end
         A_MINSTRET:  begin w_rdata = CNT_EN ? r_minstret[31:0] : '0; w_ro = !CNT_EN; end
         A_MINSTRETH: begin w_rdata = CNT_EN ? r_minstret[63:32]: '0; w_ro = !CNT_EN; end
         A_MHARTID:   begin w_rdata = 32'(HART_ID); w_ro = 1'b1; end
         default:     w_mapped = 1'b0;
      endcase
   end

   always_comb begin
      case (csr_op)
         2'b01:   w_new = csr_wdata;
         2'b10:   w_new = w_rdata | csr_wdata;
         2'b11:   w_new = w_rdata & ~csr_wdata;
         default: w_new = w_rdata;
      endcase
   end

   assign csr_rdata   = w_rdata;
   assign csr_illegal = !w_mapped || ((csr_op != 2'b00) && w_ro);
   // A trap or mret in the same cycle swallows the CSR access completely.
   assign w_wr        = (csr_op != 2'b00) && !csr_illegal && !trap_req && !mret;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_mtval        <= '0;
      end else if (trap_req) begin
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
         r_mepc         <= trap_pc & EPC_MASK;
         r_mcause       <= trap_cause;
         r_mtval        <= trap_val;
      end else if (mret) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (w_wr) begin
         case (csr_addr)
            A_MSTATUS: begin
               r_mstatus_mie  <= w_new[3];
               r_mstatus_mpie <= w_new[7];
            end
            A_MEPC:   r_mepc   <= w_new & EPC_MASK;
            A_MCAUSE: r_mcause <= w_new;
            A_MTVAL:  r_mtval  <= w_new;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mie      <= '0;
         r_mtvec    <= MTVEC_RESET;
         r_mscratch <= '0;
      end else if (w_wr) begin
         case (csr_addr)
            A_MIE:      r_mie      <= w_new & MIE_MASK;
            A_MTVEC:    r_mtvec    <= w_new & MTVEC_MASK;
            A_MSCRATCH: r_mscratch <= w_new;
            default:    ;
         endcase
      end
   end

   // A write to either half replaces it and holds the counter for that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   r_mcycle <= '0;
      else if (w_wr && (csr_addr == A_MCYCLE))   r_mcycle[31:0]  <= w_new;
      else if (w_wr && (csr_addr == A_MCYCLEH))  r_mcycle[63:32] <= w_new;
      else if (CNT_EN)                           r_mcycle <= r_mcycle + 64'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    r_minstret <= '0;
      else if (w_wr && (csr_addr == A_MINSTRET))  r_minstret[31:0]  <= w_new;
      else if (w_wr && (csr_addr == A_MINSTRETH)) r_minstret[63:32] <= w_new;
      else if (CNT_EN && instret_inc)             r_minstret <= r_minstret + 64'd1;
   end

   assign irq_take = r_mstatus_mie && (w_pend != '0);

   always_comb begin
      if (w_pend[11])     irq_cause = 32'h8000_000B;
      else if (w_pend[3]) irq_cause = 32'h8000_0003;
      else if (w_pend[7]) irq_cause = 32'h8000_0007;
      else                irq_cause = '0;
   end

   assign w_base      = {r_mtvec[31:2], 2'b00};
   assign trap_vector = (r_mtvec[0] && trap_cause[31])
                        ? w_base + ({1'b0, trap_cause[30:0]} << 2)
                        : w_base;
   assign epc_out     = r_mepc;

endmodule

// File: tb/tb_csr_machine_unit.sv
// Bench for csr_machine_unit: directed scenarios plus random traffic, checked
// against a behavioural CSR model through an expected-response queue.
module tb_csr_machine_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0206;
  localparam int          HART      = 5;

  logic        clk;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret;
  logic        instret_inc;
  logic        irq_ext;
  logic        irq_tim;
  logic        irq_sw;
  logic        irq_take;
  logic [31:0] irq_cause;
  logic [31:0] trap_vector;
  logic [31:0] epc_out;

  csr_machine_unit #(
    .XLEN(32), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART), .CNT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_val(trap_val), .mret(mret), .instret_inc(instret_inc),
    .irq_ext(irq_ext), .irq_tim(irq_tim), .irq_sw(irq_sw),
    .irq_take(irq_take), .irq_cause(irq_cause), .trap_vector(trap_vector),
    .epc_out(epc_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_mie_st;
  bit          m_mpie;
  logic [31:0] m_mie;
  logic [31:0] m_mtvec;
  logic [31:0] m_mscratch;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic [31:0] m_mtval;
  logic [63:0] m_cycle;
  logic [63:0] m_instret;

  function automatic void model_reset();
    m_mie_st   = 1'b0;
    m_mpie     = 1'b0;
    m_mie      = 32'h0;
    m_mtvec    = MTVEC_RST;
    m_mscratch = 32'h0;
    m_mepc     = 32'h0;
    m_mcause   = 32'h0;
    m_mtval    = 32'h0;
    m_cycle    = 64'h0;
    m_instret  = 64'h0;
  endfunction

  function automatic bit model_mapped(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_illegal(input logic [11:0] a, input logic [1:0] op);
    bit ro;
    ro = (a == 12'h301) || (a == 12'h344) || (a == 12'hF14);
    return !model_mapped(a) || (op != 2'b00 && ro);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie_st) << 3) | (32'(m_mpie) << 7);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(irq_ext) << 11) | (32'(irq_tim) << 7) | (32'(irq_sw) << 3);
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return 32'(HART);
      default: return 32'h0;
    endcase
  endfunction

  // State after one clock edge, given the inputs currently applied.
  function automatic void model_update();
    logic [31:0] old_v;
    logic [31:0] nv;
    bit          do_wr;
    bit          cyc_wr;
    bit          ins_wr;
    if (rst) begin
      model_reset();
      return;
    end
    old_v  = model_read(csr_addr);
    do_wr  = (csr_op != 2'b00) && !model_illegal(csr_addr, csr_op) && !trap_req && !mret;
    nv     = (csr_op == 2'b01) ? csr_wdata :
             (csr_op == 2'b10) ? (old_v | csr_wdata) : (old_v & ~csr_wdata);
    cyc_wr = 1'b0;
    ins_wr = 1'b0;
    if (trap_req) begin
      m_mepc   = trap_pc - (trap_pc % 4);
      m_mcause = trap_cause;
      m_mtval  = trap_val;
      m_mpie   = m_mie_st;
      m_mie_st = 1'b0;
    end else if (mret) begin
      m_mie_st = m_mpie;
      m_mpie   = 1'b1;
    end else if (do_wr) begin
      case (csr_addr)
        12'h300: begin m_mie_st = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie      = nv & 32'h888;
        12'h305: m_mtvec    = nv & 32'hFFFF_FFFD;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        12'hB00: begin m_cycle[31:0]    = nv; cyc_wr = 1'b1; end
        12'hB80: begin m_cycle[63:32]   = nv; cyc_wr = 1'b1; end
        12'hB02: begin m_instret[31:0]  = nv; ins_wr = 1'b1; end
        12'hB82: begin m_instret[63:32] = nv; ins_wr = 1'b1; end
        default: ;
      endcase
    end
    if (!cyc_wr) m_cycle = m_cycle + 64'd1;
    if (!ins_wr && instret_inc) m_instret = m_instret + 64'd1;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        ill;
    logic        take;
    logic [31:0] cause;
    logic [31:0] tvec;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  function automatic exp_t model_expect();
    exp_t        e;
    logic [31:0] pend;
    logic [31:0] base;
    e.addr  = csr_addr;
    e.ill   = model_illegal(csr_addr, csr_op);
    e.rdata = model_read(csr_addr);
    pend    = model_read(12'h344) & m_mie;
    e.take  = m_mie_st && (pend != 32'h0);
    if (irq_ext && m_mie[11])     e.cause = 32'h8000_000B;
    else if (irq_sw && m_mie[3])  e.cause = 32'h8000_0003;
    else if (irq_tim && m_mie[7]) e.cause = 32'h8000_0007;
    else                          e.cause = 32'h0;
    base = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[0] && trap_cause[31])
      e.tvec = base + 32'(4 * longint'(trap_cause & 32'h7FFF_FFFF));
    else
      e.tvec = base;
    e.epc = m_mepc;
    return e;
  endfunction

  task automatic check(input string name, input logic [11:0] a,
                       input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s addr=%h got=%h expected=%h @%0t", name, a, act, expv, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("csr_rdata",   mon_e.addr, csr_rdata,          mon_e.rdata);
      check("csr_illegal", mon_e.addr, 32'(csr_illegal),   32'(mon_e.ill));
      check("irq_take",    mon_e.addr, 32'(irq_take),      32'(mon_e.take));
      check("irq_cause",   mon_e.addr, irq_cause,          mon_e.cause);
      check("trap_vector", mon_e.addr, trap_vector,        mon_e.tvec);
      check("epc_out",     mon_e.addr, epc_out,            mon_e.epc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    csr_addr    = 12'h300;
    csr_op      = 2'b00;
    csr_wdata   = 32'h0;
    trap_req    = 1'b0;
    trap_cause  = 32'h0;
    trap_pc     = 32'h0;
    trap_val    = 32'h0;
    mret        = 1'b0;
    instret_inc = 1'b0;
  endtask

  // One cycle: record the expectation for the applied inputs, clock, advance the model.
  task automatic step();
    exp_q.push_back(model_expect());
    @(posedge clk);
    model_update();
    #1;
    idle();
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = d;
    step();
  endtask

  task automatic rd(input logic [11:0] a);
    csr_addr = a;
    step();
  endtask

  localparam logic [11:0] ADDRS [0:16] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h000, 12'hB01
  };

  // ---------------- stimulus ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    irq_ext = 1'b0;
    irq_tim = 1'b0;
    irq_sw  = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    #1;

    // reset state
    rd(12'h300);
    rd(12'h305);
    rd(12'hB00);
    rst = 1'b0;
    rd(12'hB00);
    rd(12'hB00);
    rd(12'hF14);
    rd(12'h301);

    // set/clear on mie
    wr(12'h304, 2'b01, 32'hFFFF_FFFF);
    rd(12'h304);
    wr(12'h304, 2'b11, 32'h0000_0008);
    rd(12'h304);
    wr(12'h304, 2'b10, 32'h0000_0001);
    rd(12'h304);

    // trap entry then mret
    wr(12'h300, 2'b10, 32'h0000_0008);
    rd(12'h300);
    trap_req = 1'b1; trap_pc = 32'h103; trap_cause = 32'hB; trap_val = 32'h55;
    csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'h1234;
    step();
    rd(12'h341);
    rd(12'h300);
    rd(12'h342);
    rd(12'h343);
    rd(12'h340);
    mret = 1'b1; csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'h9999;
    step();
    rd(12'h300);
    rd(12'h340);

    // vectored and direct trap vectors
    wr(12'h305, 2'b01, 32'h0000_1001);
    trap_cause = 32'h8000_0007; rd(12'h305);
    trap_cause = 32'h0000_0005; rd(12'h305);
    wr(12'h305, 2'b01, 32'h0000_2002);
    trap_cause = 32'h8000_0007; rd(12'h305);

    // interrupt priority
    wr(12'h304, 2'b01, 32'h0000_0888);
    wr(12'h300, 2'b10, 32'h0000_0008);
    irq_tim = 1'b1; irq_ext = 1'b1;
    rd(12'h344);
    irq_ext = 1'b0; irq_sw = 1'b1;
    rd(12'h344);
    irq_sw = 1'b0;
    rd(12'h344);
    irq_ext = 1'b1;
    wr(12'h300, 2'b11, 32'h0000_0008);
    rd(12'h344);
    irq_ext = 1'b0; irq_tim = 1'b0;
    rd(12'h344);

    // counter carry, write priority and 64-bit wrap
    wr(12'hB80, 2'b01, 32'h0);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00);
    rd(12'hB00);
    rd(12'hB80);
    wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB80);
    rd(12'hB00);
    instret_inc = 1'b1; csr_addr = 12'hB02; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF;
    step();
    instret_inc = 1'b1; rd(12'hB02);
    rd(12'hB82);
    instret_inc = 1'b1; csr_addr = 12'hB82; csr_op = 2'b01; csr_wdata = 32'h7;
    step();
    rd(12'hB82);
    rd(12'hB02);

    // illegal accesses leave state untouched
    wr(12'h301, 2'b01, 32'h0);
    rd(12'h301);
    wr(12'h7C0, 2'b01, 32'hFFFF_FFFF);
    wr(12'h344, 2'b10, 32'hFFFF_FFFF);
    wr(12'hF14, 2'b11, 32'hFFFF_FFFF);
    rd(12'hF14);
    trap_req = 1'b1; trap_pc = 32'h400; trap_cause = 32'h2;
    csr_addr = 12'h305; csr_op = 2'b01; csr_wdata = 32'hABCD_0000;
    step();
    rd(12'h305);

    // reset in the middle of a pending write
    wr(12'h340, 2'b01, 32'h1111_2222);
    csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'hDEAD_BEEF;
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    idle();
    rd(12'h340);
    rst = 1'b0;
    rd(12'h340);
    rd(12'hB00);
    rd(12'h305);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      csr_addr    = ADDRS[$urandom_range(0, 16)];
      csr_op      = 2'($urandom_range(0, 3));
      csr_wdata   = $urandom;
      if ($urandom_range(0, 3) == 0) csr_wdata = csr_wdata | 32'h0000_0888;
      trap_req    = ($urandom_range(0, 11) == 0);
      mret        = ($urandom_range(0, 11) == 0);
      trap_cause  = $urandom;
      trap_pc     = $urandom;
      trap_val    = $urandom;
      instret_inc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
      if ($urandom_range(0, 7) == 0) irq_tim = ~irq_tim;
      if ($urandom_range(0, 7) == 0) irq_sw  = ~irq_sw;
      step();
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_machine_unit.md
CSR_MACHINE_UNIT -- requirements
Module: csr_machine_unit

Interface
REQ-001 Parameter XLEN, default 32: CSR data width; only 32 is legal.
REQ-002 Parameter MTVEC_RESET, default 32'h0000_0000: reset value of mtvec.
REQ-003 Parameter HART_ID, default 0: value returned by mhartid.
REQ-004 Parameter CNT_EN, default 1: when 1, mcycle and minstret are implemented; when 0, they read 0 and are read-only.
REQ-005 Reset rst, asynchronous, active-high; clock clk.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 csr_addr  in  12  full CSR address.
REQ-009 csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
REQ-010 csr_wdata  in  XLEN  operand for write, set or clear.
REQ-011 csr_rdata  out  XLEN  combinational read of csr_addr, before this cycle's update.
REQ-012 csr_illegal  out  1  combinational; unmapped address, or csr_op!=00 to a read-only CSR.
REQ-013 trap_req  in  1  trap entry this cycle.
REQ-014 trap_cause  in  XLEN  value for mcause (bit31 set marks an interrupt).
REQ-015 trap_pc  in  XLEN  PC to save in mepc.
REQ-016 trap_val  in  XLEN  value for mtval.
REQ-017 mret  in  1  return from trap this cycle.
REQ-018 instret_inc  in  1  one instruction retired this cycle.
REQ-019 irq_ext, irq_tim, irq_sw  in  1 each  level interrupt lines.
REQ-020 irq_take  out  1  an enabled interrupt is pending.
REQ-021 irq_cause  out  XLEN  cause of the highest-priority pending interrupt.
REQ-022 trap_vector  out  XLEN  handler address for the current trap_cause.
REQ-023 epc_out  out  XLEN  current mepc value.

Function
REQ-024 Address map and write masks:
- mstatus 0x300: mask 0x1888; MPP (bits 12:11) always reads 11.
- misa 0x301: read-only, 0x4000_0100.
- mie 0x304: mask 0x888.
- mtvec 0x305: mask 0xFFFF_FFFD.
- mscratch 0x340: all bits writable.
- mepc 0x341: mask 0xFFFF_FFFC.
- mcause 0x342, mtval 0x343: all bits writable.
- mip 0x344: read-only.
- mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: all bits writable.
- mhartid 0xF14: read-only.
REQ-025 Op results: write gives new=d; set gives new=old|d; clear gives new=old&~d. The masked result is registered at the next rising clk.
REQ-026 When csr_illegal=1, no state changes; csr_rdata=0 for an unmapped address.
REQ-027 mip reads {20'b0, irq_ext, 3'b0, irq_tim, 3'b0, irq_sw, 3'b0}, sampled live from the inputs.
REQ-028 irq_take = mstatus.MIE & |(mip & mie).
REQ-029 irq_cause priority: external 0x8000_000B, then software 0x8000_0003, then timer 0x8000_0007; irq_cause=0 when none is pending.
REQ-030 Trap entry (trap_req=1), at the next edge:
- mepc<=trap_pc&~3; mcause<=trap_cause; mtval<=trap_val.
- MPIE<=MIE; MIE<=0; MPP<=11.
REQ-031 mret=1, at the next edge: MIE<=MPIE; MPIE<=1.
REQ-032 Same-cycle priority: trap_req > mret > csr_op. A lower-priority event in the same cycle is dropped entirely.
REQ-033 trap_vector:
- mtvec[0]=0 (direct): {mtvec[31:2],2'b00}.
- mtvec[0]=1 (vectored) and trap_cause[31]=1: base + 4*trap_cause[30:0].
- mtvec[0]=1 and trap_cause[31]=0 (exception): base only.
REQ-034 mcycle is a 64-bit counter incremented every cycle; a carry from the low word into the high word occurs in the same cycle.
REQ-035 minstret is 64 bits and increments when instret_inc=1.
REQ-036 A CSR write to any counter half replaces that half that cycle and suppresses that counter's increment for the cycle. The other half is unchanged and receives no carry.
REQ-037 Wrap-around: 0xFFFF_FFFF_FFFF_FFFF increments to 0.
REQ-038 Counters keep running during trap entry and mret cycles.

Reset
REQ-039 While rst=1, all state is forced asynchronously and held:
- mstatus=0x1800; mie=0; mtvec=MTVEC_RESET.
- mscratch, mepc, mcause, mtval, mcycle and minstret all 0.
REQ-040 The first increment occurs at the first rising clk after rst deasserts. Reset asserted mid-operation aborts any pending update.
REQ-041 Reset values of outputs: irq_take=0, epc_out=0, trap_vector=MTVEC_RESET&~3.

Verification
REQ-042 Set/clear: write mie=0xFFFF_FFFF -> reads 0x888; clear 0x008 -> reads 0x880; set 0x001 -> reads 0x880.
REQ-043 Trap then mret: MIE=1, trap_req with trap_pc=0x103 and cause 0xB -> mepc=0x100, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
REQ-044 Vectored interrupt: mtvec written 0x1001, trap_cause=0x8000_0007 -> trap_vector=0x101C.
REQ-045 Interrupt priority: MIE=1, mie=0x888, irq_tim=irq_ext=1 -> irq_take=1, irq_cause=0x8000_000B; with MIE=0 -> irq_take=0.
REQ-046 Counter carry: write mcycle=0xFFFF_FFFF -> next cycle mcycle=0 and mcycleh=1; a write to mcycle in the same cycle as an increment -> the written value wins.
REQ-047 Illegal access: write to misa or 0x7C0 -> csr_illegal=1 and no state changes; trap_req together with a write to mtvec -> mtvec is unchanged.
